// File: rtl/branch_pred_queue.sv
// rtl/branch_pred_queue.sv - in-order branch prediction tracking queue with tournament training strobes
module branch_pred_queue #(
  parameter int DEPTH     = 8,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [PC_WIDTH-1:0]  enq_pc,
  input  logic [PC_WIDTH-1:0]  enq_target,
  input  logic                 enq_pred_taken,
  input  logic                 enq_global_pred,
  input  logic                 enq_local_pred,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [PC_WIDTH-1:0]  res_target,
  output logic                 upd_valid,
  output logic                 upd_br_en,
  output logic [PC_WIDTH-1:0]  upd_pc,
  output logic                 upd_meta_inc,
  output logic                 upd_meta_dec,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 res_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_WIDTH-1:0] pc_mem  [DEPTH];
  logic [PC_WIDTH-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0]    pred_mem;
  logic [DEPTH-1:0]    glob_mem;
  logic [DEPTH-1:0]    loc_mem;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic full;
  logic empty;
  logic do_res;
  logic do_enq;
  logic dir_wrong;
  logic tgt_wrong;
  logic mp;
  logic [PC_WIDTH-1:0] e_pc;
  logic [PC_WIDTH-1:0] e_tgt;
  logic e_pred;
  logic e_glob;
  logic e_loc;

  assign full      = (count == CNT_WIDTH'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full;

  assign e_pc   = pc_mem[head];
  assign e_tgt  = tgt_mem[head];
  assign e_pred = pred_mem[head];
  assign e_glob = glob_mem[head];
  assign e_loc  = loc_mem[head];

  assign do_res    = res_valid & !empty;
  assign dir_wrong = e_pred ^ res_taken;
  assign tgt_wrong = res_taken & e_pred & (res_target != e_tgt);
  assign mp        = dir_wrong | tgt_wrong;
  // A flushing resolve also swallows any push offered in the same cycle.
  assign do_enq    = enq_valid & enq_ready & !(do_res & mp);

  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem[tail]   <= enq_pc;
      tgt_mem[tail]  <= enq_target;
      pred_mem[tail] <= enq_pred_taken;
      glob_mem[tail] <= enq_global_pred;
      loc_mem[tail]  <= enq_local_pred;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (do_res && mp) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + PTR_W'(1);
      if (do_res) head <= head + PTR_W'(1);
      if (do_enq && !do_res)      count <= count + CNT_WIDTH'(1);
      else if (!do_enq && do_res) count <= count - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid    <= 1'b0;
      upd_br_en    <= 1'b0;
      upd_pc       <= '0;
      upd_meta_inc <= 1'b0;
      upd_meta_dec <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
      res_err      <= 1'b0;
    end else begin
      upd_valid    <= do_res;
      upd_meta_inc <= do_res & (e_glob == res_taken) & (e_loc != res_taken);
      upd_meta_dec <= do_res & (e_loc == res_taken) & (e_glob != res_taken);
      mispredict   <= do_res & mp;
      if (do_res) begin
        upd_br_en   <= res_taken;
        upd_pc      <= e_pc;
        redirect_pc <= res_taken ? res_target : e_pc + PC_WIDTH'(4);
      end
      if (res_valid && empty) res_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_queue.sv
// tb/tb_branch_pred_queue.sv - directed self-checking bench for branch_pred_queue
module tb_branch_pred_queue;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_target;
  logic        enq_pred_taken;
  logic        enq_global_pred;
  logic        enq_local_pred;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_valid;
  logic        upd_br_en;
  logic [31:0] upd_pc;
  logic        upd_meta_inc;
  logic        upd_meta_dec;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic        res_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_pc;

  branch_pred_queue dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_target(enq_target),
    .enq_pred_taken(enq_pred_taken), .enq_global_pred(enq_global_pred), .enq_local_pred(enq_local_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_br_en(upd_br_en), .upd_pc(upd_pc),
    .upd_meta_inc(upd_meta_inc), .upd_meta_dec(upd_meta_dec),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic p, input logic g, input logic l);
    enq_valid = 1'b1; enq_pc = pc; enq_target = tgt;
    enq_pred_taken = p; enq_global_pred = g; enq_local_pred = l;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    res_valid = 1'b1; res_taken = taken; res_target = tgt;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enq_valid = 1'b0; enq_pc = '0; enq_target = '0;
    enq_pred_taken = 1'b0; enq_global_pred = 1'b0; enq_local_pred = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(enq_ready), 1);
    check("rst_upd_valid", 32'(upd_valid), 0);
    check("rst_mispredict", 32'(mispredict), 0);
    check("rst_res_err", 32'(res_err), 0);
    step(); step();
    rst = 1'b1;
    step();

    // three branches resolved as predicted
    push(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    push(32'h20, 32'h80, 1'b1, 1'b1, 1'b1);
    push(32'h30, 32'h0, 1'b0, 1'b0, 1'b1);
    check("t1_count3", 32'(count), 3);
    resolve(1'b0, 32'h0);
    check("t1a_valid", 32'(upd_valid), 1);
    check("t1a_pc", upd_pc, 32'h10);
    check("t1a_mp", 32'(mispredict), 0);
    check("t1a_br", 32'(upd_br_en), 0);
    check("t1a_inc", 32'(upd_meta_inc), 0);
    step();
    check("t1_gap_valid", 32'(upd_valid), 0);
    resolve(1'b1, 32'h80);
    check("t1b_pc", upd_pc, 32'h20);
    check("t1b_mp", 32'(mispredict), 0);
    check("t1b_br", 32'(upd_br_en), 1);
    resolve(1'b0, 32'h0);
    check("t1c_pc", upd_pc, 32'h30);
    check("t1c_inc", 32'(upd_meta_inc), 1);
    check("t1c_mp", 32'(mispredict), 0);
    check("t1_count0", 32'(count), 0);
    step();
    check("t1_inc_pulse", 32'(upd_meta_inc), 0);

    // direction mispredict, taken to 0x200
    push(32'h100, 32'h104, 1'b0, 1'b1, 1'b0);
    resolve(1'b1, 32'h200);
    check("t2_mp", 32'(mispredict), 1);
    check("t2_redirect", redirect_pc, 32'h200);
    check("t2_inc", 32'(upd_meta_inc), 1);
    check("t2_dec", 32'(upd_meta_dec), 0);
    check("t2_br", 32'(upd_br_en), 1);
    step();
    check("t2_mp_pulse", 32'(mispredict), 0);

    // flush with 4 queued and a concurrent push that must be dropped
    push(32'h400, 32'h500, 1'b1, 1'b1, 1'b0);
    push(32'h410, 32'h0, 1'b0, 1'b0, 1'b0);
    push(32'h420, 32'h0, 1'b0, 1'b0, 1'b0);
    push(32'h430, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t3_count4", 32'(count), 4);
    enq_valid = 1'b1; enq_pc = 32'h999; enq_pred_taken = 1'b0;
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    enq_valid = 1'b0; res_valid = 1'b0;
    check("t3_mp", 32'(mispredict), 1);
    check("t3_redirect", redirect_pc, 32'h404);
    check("t3_dec", 32'(upd_meta_dec), 1);
    check("t3_count0", 32'(count), 0);
    push(32'h600, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t3_count1", 32'(count), 1);
    resolve(1'b0, 32'h0);
    check("t3_next_pc", upd_pc, 32'h600);

    // fill, blocked push on full, then FIFO order across pointer wrap
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 1'b0);
      model_q.push_back(32'h1000 + 32'(i * 4));
    end
    check("t4_count8", 32'(count), 8);
    check("t4_full_ready", 32'(enq_ready), 0);
    enq_valid = 1'b1; enq_pc = 32'hBAD; enq_pred_taken = 1'b0;
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    enq_valid = 1'b0; res_valid = 1'b0;
    exp_pc = model_q.pop_front();
    check("t4_full_pop_pc", upd_pc, exp_pc);
    check("t4_count7", 32'(count), 7);
    check("t4_ready", 32'(enq_ready), 1);
    for (int i = 0; i < 24; i++) begin
      enq_valid = 1'b1; enq_pc = 32'h2000 + 32'(i * 4);
      enq_pred_taken = 1'b0; enq_global_pred = 1'b0; enq_local_pred = 1'b0;
      res_valid = 1'b1; res_taken = 1'b0;
      model_q.push_back(32'h2000 + 32'(i * 4));
      step();
      exp_pc = model_q.pop_front();
      check("t4_wrap_pc", upd_pc, exp_pc);
      check("t4_wrap_mp", 32'(mispredict), 0);
    end
    enq_valid = 1'b0; res_valid = 1'b0;
    check("t4_count_steady", 32'(count), 7);
    while (model_q.size() > 0) begin
      resolve(1'b0, 32'h0);
      exp_pc = model_q.pop_front();
      check("t4_drain_pc", upd_pc, exp_pc);
    end
    check("t4_count_drained", 32'(count), 0);

    // resolve against an empty queue
    resolve(1'b1, 32'h0);
    check("t5_valid", 32'(upd_valid), 0);
    check("t5_mp", 32'(mispredict), 0);
    check("t5_err", 32'(res_err), 1);
    check("t5_count", 32'(count), 0);
    step(); step();
    check("t5_err_sticky", 32'(res_err), 1);

    // asynchronous reset with 5 queued and a strobe pending
    for (int i = 0; i < 6; i++) push(32'h3000 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 1'b0);
    resolve(1'b0, 32'h0);
    check("t6_pre_count", 32'(count), 5);
    check("t6_pre_valid", 32'(upd_valid), 1);
    rst = 1'b0;
    #1;
    check("t6_count", 32'(count), 0);
    check("t6_ready", 32'(enq_ready), 1);
    check("t6_valid", 32'(upd_valid), 0);
    check("t6_err", 32'(res_err), 0);
    step(); step();
    rst = 1'b1;
    step();
    push(32'h700, 32'h800, 1'b1, 1'b0, 1'b1);
    check("t6_count1", 32'(count), 1);
    resolve(1'b1, 32'h800);
    check("t6_upd_valid", 32'(upd_valid), 1);
    check("t6_pc", upd_pc, 32'h700);
    check("t6_mp", 32'(mispredict), 0);
    check("t6_dec", 32'(upd_meta_dec), 1);
    check("t6_count0", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_pred_queue.md
# branch_pred_queue

In-order tracking queue for branch predictions between fetch and execute. Each fetched branch is pushed with its tournament prediction (final, global and local component predictions) and predicted target. Resolutions from execute pop the oldest entry and produce the registered training strobes for the tournament predictor and its global/local tables. A mispredict also produces the flush and redirect for fetch and discards every younger in-flight entry.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 2
- PC_WIDTH, 32, PC and target width
- CNT_WIDTH, $clog2(DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state while low
- enq_valid  in  1  fetch pushes a branch this cycle
- enq_ready  out  1  equals !full; an enqueue is accepted only when enq_valid & enq_ready
- enq_pc  in  PC_WIDTH  branch PC
- enq_target  in  PC_WIDTH  predicted target
- enq_pred_taken  in  1  final tournament prediction
- enq_global_pred  in  1  global component prediction
- enq_local_pred  in  1  local component prediction
- res_valid  in  1  execute resolves the oldest branch
- res_taken  in  1  actual direction
- res_target  in  PC_WIDTH  actual target, meaningful when res_taken=1
- upd_valid  out  1  training strobe to the predictors (their pred_ld)
- upd_br_en  out  1  actual direction for training
- upd_pc  out  PC_WIDTH  PC of the trained branch, used for table indexing
- upd_meta_inc  out  1  move the meta counter toward global
- upd_meta_dec  out  1  move the meta counter toward local
- mispredict  out  1  flush strobe to fetch
- redirect_pc  out  PC_WIDTH  correct next PC, valid with mispredict
- count  out  CNT_WIDTH  current occupancy
- res_err  out  1  sticky: res_valid was seen with the queue empty

## Operation
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The count register distinguishes full from empty. full = (count==DEPTH); empty = (count==0).
- Enqueue: an accepted push writes the entry at tail; tail is incremented.
- Resolve with the queue non-empty pops the head entry (E) and evaluates:
  - dir_wrong = E.pred_taken ^ res_taken
  - tgt_wrong = res_taken & E.pred_taken & (res_target != E.target)
  - mp = dir_wrong | tgt_wrong
- Registered outputs, one cycle after the resolve:
  - upd_valid=1, upd_br_en=res_taken, upd_pc=E.pc
  - upd_meta_inc = (E.global_pred==res_taken) & (E.local_pred!=res_taken)
  - upd_meta_dec = (E.local_pred==res_taken) & (E.global_pred!=res_taken)
  - mispredict=mp
  - redirect_pc = res_taken ? res_target : E.pc+4, truncated to PC_WIDTH (wrap-around at the top of the address space is allowed)
- Flush: when mp=1, the edge that pops the head also sets head=tail=0 and count=0. All younger entries are discarded. An enqueue offered in that same cycle is dropped, even if enq_ready=1.
- Resolve with the queue empty: ignored. No update strobes, no state change. res_err is set and stays set until reset.
- Simultaneous accepted enqueue and non-mispredicting resolve: both take effect and count is unchanged.
- Full with a resolve in the same cycle: enq_ready stays 0 (no bypass), so the push is not accepted that cycle.
- Single-cycle strobes: upd_valid, mispredict, upd_meta_inc and upd_meta_dec are 1 for exactly one cycle per resolve.

## Timing
- Reset (rst low, asynchronous): head=tail=0, count=0, res_err=0. All outputs read 0, except enq_ready, which reads 1. Entry contents are don't-care.
- Reset mid-operation: all entries are discarded immediately. Pending strobes clear without waiting for a clock edge.
- Enqueue-to-resolve: an entry pushed at edge N can be resolved in the cycle after edge N. Same-cycle push-and-resolve of that entry is not supported; with an empty queue it counts as an empty resolve.
- Resolve-to-update latency: exactly 1 cycle. All upd_* outputs, mispredict and redirect_pc come from flops.
- enq_ready and count are derived from registered state only, with no combinational path from res_valid. Throughput is one enqueue and one resolve per cycle.

## Test plan
- Reset, push 3 branches, resolve each as predicted: 3 upd_valid pulses, mispredict never 1, count ends at 0.
- Push PC=0x100 with pred_taken=0, global=1, local=0; resolve taken to 0x200: next cycle mispredict=1, redirect_pc=0x200, upd_meta_inc=1, upd_br_en=1.
- Push 4 entries and resolve the oldest as not-taken against a taken prediction, with enq_valid=1 in that cycle: redirect_pc = that entry's PC+4, count=0 after the edge, the enqueue is dropped.
- Fill to DEPTH entries: enq_ready=0. Then drive resolve and enqueue together: the push is not accepted. Continue pushes and pops across pointer wrap for 3×DEPTH entries and check FIFO order of upd_pc.
- Drive res_valid with the queue empty: no upd_valid, res_err=1 and stays 1, count stays 0.
- Drop rst to 0 mid-stream with 5 entries queued: count=0 and enq_ready=1 immediately. After release, the first push and resolve behave as after a fresh reset.
